// File: rtl/hndshk_pkg.sv
// Shared types and constants for the t_rdy/t_data/r_ack CDC handshake channel.
package hndshk_pkg;

    localparam int unsigned HNDSHK_DATA_W = 32;

    typedef enum logic [1:0] {
        DRAIN   = 2'd0,
        IDLE    = 2'd1,
        REQ     = 2'd2,
        RELEASE = 2'd3
    } hndshk_tx_state_t;

endpackage

// File: rtl/cdc_sync_bit.sv
// Multi-flop single-bit synchronizer; q follows d after STAGES clocks.
module cdc_sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/hndshk_tx_arbiter.sv
// Round-robin transmit scheduler for the 4-phase t_rdy/t_data/r_ack channel (tclk domain).
// Optional ack watchdog enabled by defining HNDSHK_TIMEOUT_EN.
module hndshk_tx_arbiter
    import hndshk_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_W      = HNDSHK_DATA_W,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT_W   = 16
) (
    input  logic                        tclk,
    input  logic                        reset_tclk,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        t_rdy,
    output logic [DATA_W-1:0]           t_data,
    input  logic                        r_ack,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy,
    output logic                        xfer_done,
    output logic                        timeout_err
);

    localparam int unsigned ID_W   = $clog2(NUM_REQ);
    localparam int unsigned DCNT_W = $clog2(SYNC_STAGES + 1);

    if (NUM_REQ < 2 || SYNC_STAGES < 2 || TIMEOUT_W < 1) begin : g_param_check
        $error("hndshk_tx_arbiter: illegal parameter combination");
    end

    hndshk_tx_state_t  state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   grant;
    logic              any_valid;
    logic              ack_s;
    logic [DCNT_W-1:0] drain_cnt;
    logic [DATA_W-1:0] lane [NUM_REQ];

    cdc_sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk   (tclk),
        .reset (reset_tclk),
        .d     (r_ack),
        .q     (ack_s)
    );

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign lane[i] = req_data[i*DATA_W +: DATA_W];
    end

    // First valid requester above ptr, wrapping; scanning downward lets the nearest win.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                 input logic [ID_W-1:0]    ptr);
        logic [ID_W-1:0] pick;
        int unsigned     idx;
        pick = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (valid[ID_W'(idx)]) pick = ID_W'(idx);
        end
        return pick;
    endfunction

    always_comb begin
        req_ready = '0;
        any_valid = |req_valid;
        grant     = rr_pick(req_valid, rr_ptr);
        if (state == IDLE && any_valid) req_ready[grant] = 1'b1;
    end

    // DRAIN first lets the synchronizer refill so a stale ack from before reset is seen.
    always_ff @(posedge tclk) begin
        if (reset_tclk) begin
            state     <= DRAIN;
            busy      <= 1'b1;
            t_rdy     <= 1'b0;
            t_data    <= '0;
            grant_id  <= '0;
            rr_ptr    <= ID_W'(NUM_REQ - 1);
            xfer_done <= 1'b0;
            drain_cnt <= '0;
        end else begin
            xfer_done <= 1'b0;
            case (state)
                DRAIN: begin
                    if (drain_cnt != DCNT_W'(SYNC_STAGES)) begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end else if (!ack_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                IDLE: begin
                    if (any_valid) begin
                        t_data   <= lane[grant];
                        t_rdy    <= 1'b1;
                        grant_id <= grant;
                        rr_ptr   <= grant;
                        state    <= REQ;
                        busy     <= 1'b1;
                    end
                end
                REQ: begin
                    if (ack_s) begin
                        t_rdy <= 1'b0;
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!ack_s) begin
                        xfer_done <= 1'b1;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= DRAIN;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

`ifdef HNDSHK_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] wd_cnt;
    logic                 wd_active;

    assign wd_active = (state == REQ) || (state == RELEASE);

    // Watchdog only flags a stuck ack; the handshake itself is never aborted.
    always_ff @(posedge tclk) begin
        if (reset_tclk) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if ((state == IDLE && any_valid) || (state == REQ && ack_s)) begin
                wd_cnt <= '0;
            end else if (wd_active && wd_cnt != '1) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (wd_active && wd_cnt == '1) timeout_err <= 1'b1;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_hndshk_tx_arbiter.sv
// Directed self-checking bench for hndshk_tx_arbiter with a 3-cycle-latency receiver model.
module tb_hndshk_tx_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned DATA_W  = 32;

    logic                      tclk = 1'b0;
    logic                      reset_tclk;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      t_rdy;
    logic [DATA_W-1:0]         t_data;
    logic                      r_ack = 1'b0;
    logic [1:0]                grant_id;
    logic                      busy;
    logic                      xfer_done;
    logic                      timeout_err;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;

    bit         model_en  = 1'b1;
    bit         ack_force = 1'b0;
    logic [2:0] rdy_dly   = '0;

    hndshk_tx_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .DATA_W      (DATA_W),
        .SYNC_STAGES (2),
        .TIMEOUT_W   (4)
    ) dut (
        .tclk        (tclk),
        .reset_tclk  (reset_tclk),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .t_rdy       (t_rdy),
        .t_data      (t_data),
        .r_ack       (r_ack),
        .grant_id    (grant_id),
        .busy        (busy),
        .xfer_done   (xfer_done),
        .timeout_err (timeout_err)
    );

    always #5 tclk = ~tclk;

    // Receiver: ack rises 3 tclk after t_rdy rises, falls 3 tclk after it drops.
    always @(posedge tclk) begin
        rdy_dly <= {rdy_dly[1:0], t_rdy};
        r_ack   <= model_en ? rdy_dly[1] : ack_force;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Continuous monitors: one-hot accept and t_data held across each transfer.
    logic [DATA_W-1:0] hold_data = '0;
    bit                in_xfer   = 1'b0;
    logic              prev_rdy  = 1'b0;

    always @(negedge tclk) begin
        check("onehot0_req_ready", 64'($onehot0(req_ready)), 64'd1);
        if (xfer_done) n_done++;
        if (reset_tclk) begin
            in_xfer = 1'b0;
        end else if (t_rdy && !prev_rdy) begin
            hold_data = t_data;
            in_xfer   = 1'b1;
        end else if (in_xfer) begin
            check("t_data_hold", 64'(t_data), 64'(hold_data));
        end
        if (xfer_done) in_xfer = 1'b0;
        prev_rdy = t_rdy;
    end

    task automatic set_lanes(input logic [31:0] base);
        for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_W +: DATA_W] = base + 32'(i);
    endtask

    task automatic do_reset(input int cycles);
        reset_tclk = 1'b1;
        repeat (cycles) @(posedge tclk);
        #1 reset_tclk = 1'b0;
    endtask

    // Returns at the negedge of the accept cycle with the granted index.
    task automatic wait_accept(input string tag, output int idx);
        bit ok = 1'b0;
        idx = -1;
        for (int c = 0; c < 60 && !ok; c++) begin
            @(negedge tclk);
            if (|(req_valid & req_ready)) begin
                ok = 1'b1;
                for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) idx = i;
            end
        end
        check({tag, "_accept_seen"}, 64'(ok), 64'd1);
    endtask

    task automatic wait_done(input string tag);
        bit ok = 1'b0;
        for (int c = 0; c < 60 && !ok; c++) begin
            @(negedge tclk);
            if (xfer_done) ok = 1'b1;
        end
        check({tag, "_done_seen"}, 64'(ok), 64'd1);
    endtask

    initial begin
        int g;
        int done_before;

        reset_tclk = 1'b1;
        req_valid  = '0;
        req_data   = '0;
        repeat (3) @(posedge tclk);
        @(negedge tclk);
        check("rst_t_rdy", 64'(t_rdy), 64'd0);
        check("rst_t_data", 64'(t_data), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_grant_id", 64'(grant_id), 64'd0);
        check("rst_xfer_done", 64'(xfer_done), 64'd0);
        check("rst_timeout_err", 64'(timeout_err), 64'd0);
        check("rst_busy", 64'(busy), 64'd1);

        // Single requester 2 after reset.
        set_lanes(32'hA5A5_0000);
        req_valid = 4'b0100;
        @(posedge tclk);
        #1 reset_tclk = 1'b0;
        done_before = n_done;
        wait_accept("t1", g);
        check("t1_req_ready", 64'(req_ready), 64'h4);
        @(posedge tclk);
        #1 req_valid = '0;
        @(negedge tclk);
        check("t1_t_rdy", 64'(t_rdy), 64'd1);
        check("t1_t_data", 64'(t_data), 64'hA5A5_0002);
        check("t1_grant_id", 64'(grant_id), 64'd2);
        check("t1_busy", 64'(busy), 64'd1);
        wait_done("t1");
        @(negedge tclk);
        check("t1_done_count", 64'(n_done - done_before), 64'd1);
        check("t1_idle_busy", 64'(busy), 64'd0);
        check("t1_t_rdy_low", 64'(t_rdy), 64'd0);

        // All requesters valid from a fresh pointer: 0,1,2,3,0,1,2,3.
        do_reset(2);
        set_lanes(32'h1234_5670);
        req_valid = 4'b1111;
        done_before = n_done;
        for (int n = 0; n < 8; n++) begin
            wait_accept("t2", g);
            check("t2_grant_order", 64'(g), 64'(n % 4));
            @(negedge tclk);
            check("t2_grant_id", 64'(grant_id), 64'(n % 4));
            check("t2_t_data", 64'(t_data), 64'(32'h1234_5670 + 32'(n % 4)));
        end
        #1 req_valid = '0;
        wait_done("t2");
        @(negedge tclk);
        check("t2_done_count", 64'(n_done - done_before), 64'd8);

        // Payload and valid change while the transfer is open.
        set_lanes(32'hBEEF_0000);
        req_valid = 4'b0001;
        wait_accept("t4", g);
        @(posedge tclk);
        #1 set_lanes(32'h0BAD_0000);
        req_valid = '0;
        wait_done("t4");
        check("t4_t_data_at_done", 64'(t_data), 64'hBEEF_0000);
        check("t4_grant_id", 64'(grant_id), 64'd0);

        // Reset in REQ with the receiver still acking.
        set_lanes(32'hCAFE_0000);
        req_valid = 4'b0010;
        wait_accept("t3", g);
        for (int c = 0; c < 20 && r_ack !== 1'b1; c++) @(negedge tclk);
        check("t3_ack_high", 64'(r_ack), 64'd1);
        @(posedge tclk);
        #1 model_en = 1'b0;
        ack_force = 1'b1;
        reset_tclk = 1'b1;
        done_before = n_done;
        @(posedge tclk);
        #1 reset_tclk = 1'b0;
        @(negedge tclk);
        check("t3_t_rdy_after_rst", 64'(t_rdy), 64'd0);
        check("t3_busy_after_rst", 64'(busy), 64'd1);
        for (int c = 0; c < 9; c++) begin
            @(negedge tclk);
            check("t3_no_accept_while_ack", 64'(req_ready), 64'd0);
        end
        @(posedge tclk);
        #1 ack_force = 1'b0;
        model_en = 1'b1;
        wait_accept("t3", g);
        check("t3_no_aborted_done", 64'(n_done - done_before), 64'd0);
        check("t3_grant", 64'(g), 64'd1);
        @(posedge tclk);
        #1 req_valid = '0;
        wait_done("t3");
        check("t3_t_data", 64'(t_data), 64'hCAFE_0001);

`ifdef HNDSHK_TIMEOUT_EN
        // Stuck ack: flag rises, protocol continues, flag stays sticky.
        model_en  = 1'b0;
        ack_force = 1'b0;
        req_valid = 4'b0100;
        wait_accept("t5", g);
        @(posedge tclk);
        #1 req_valid = '0;
        repeat (20) @(negedge tclk);
        check("t5_timeout_set", 64'(timeout_err), 64'd1);
        check("t5_t_rdy_held", 64'(t_rdy), 64'd1);
        model_en = 1'b1;
        wait_done("t5");
        @(negedge tclk);
        check("t5_timeout_sticky", 64'(timeout_err), 64'd1);
`else
        check("timeout_err_tied", 64'(timeout_err), 64'd0);
`endif

        repeat (3) @(negedge tclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
